// File: rtl/gemm_result_stream_if.sv
// rtl/gemm_result_stream_if.sv - result element stream bundle (oparity present under GEMM_STREAM_PARITY_EN)
interface gemm_result_stream_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4
);
    localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

    logic                  ovalid;
    logic                  iready;
    logic [DATA_WIDTH-1:0] odata;
    logic [RW-1:0]         orow;
    logic [CW-1:0]         ocol;
    logic                  olast;
`ifdef GEMM_STREAM_PARITY_EN
    logic                  oparity;

    modport master (output ovalid, odata, orow, ocol, olast, oparity, input iready);
    modport slave  (input ovalid, odata, orow, ocol, olast, oparity, output iready);
`else
    modport master (output ovalid, odata, orow, ocol, olast, input iready);
    modport slave  (input ovalid, odata, orow, ocol, olast, output iready);
`endif
endinterface

// File: rtl/gemm_result_stream.sv
// rtl/gemm_result_stream.sv - shadow-buffered GEMM result drain streaming one element per beat; optional GEMM_STREAM_PARITY_EN
module gemm_result_stream #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4,
    parameter bit COL_MAJOR     = 1'b0
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  idone,
    input  logic [DATA_WIDTH-1:0] iresult_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    gemm_result_stream_if.master  stream,
    output logic                  obusy,
    output logic                  ooverrun
);
    localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
    localparam int CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shadow [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic [RW-1:0]         row, row_nxt;
    logic [CW-1:0]         col, col_nxt;
    logic [DATA_WIDTH-1:0] data, data_nxt;
    logic                  last, last_nxt;
    logic                  overrun, overrun_nxt;
    logic                  fire, last_fire, capture;

    always_comb begin
        fire        = (state == STREAM) && stream.iready;
        last_fire   = fire && last;
        // A done pulse is only accepted when the shadow buffer is free or being vacated this cycle
        capture     = idone && ((state == IDLE) || last_fire);
        overrun_nxt = overrun || (idone && (state == STREAM) && !last_fire);
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;

        case (state)
            IDLE:    if (idone) state_nxt = STREAM;
            STREAM:  if (last_fire && !idone) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (capture || last_fire) begin
            row_nxt = '0;
            col_nxt = '0;
        end else if (fire) begin
            if (COL_MAJOR) begin
                if (row == ROW_LAST) begin
                    row_nxt = '0;
                    col_nxt = col + 1'b1;
                end else begin
                    row_nxt = row + 1'b1;
                end
            end else begin
                if (col == COL_LAST) begin
                    col_nxt = '0;
                    row_nxt = row + 1'b1;
                end else begin
                    col_nxt = col + 1'b1;
                end
            end
        end

        last_nxt = (state_nxt == STREAM) && (row_nxt == ROW_LAST) && (col_nxt == COL_LAST);

        // On capture the shadow is not yet loaded, so the first element bypasses it
        if (capture)
            data_nxt = iresult_matrix[0][0];
        else if (state_nxt == STREAM)
            data_nxt = shadow[row_nxt][col_nxt];
        else
            data_nxt = '0;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            data    <= '0;
            last    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            data    <= data_nxt;
            last    <= last_nxt;
            overrun <= overrun_nxt;
        end
    end

    always_ff @(posedge iclk) begin
        if (capture)
            shadow <= iresult_matrix;
    end

`ifdef GEMM_STREAM_PARITY_EN
    logic parity;

    always_ff @(posedge iclk) begin
        if (irst)
            parity <= 1'b0;
        else
            parity <= ^data_nxt;
    end

    assign stream.oparity = parity;
`endif

    assign stream.ovalid = (state == STREAM);
    assign stream.odata  = data;
    assign stream.orow   = row;
    assign stream.ocol   = col;
    assign stream.olast  = last;
    assign obusy         = (state == STREAM);
    assign ooverrun      = overrun;
endmodule
